uart_tx_serializer: RTL
=======================

// Module: uart_tx_serializer
// PURPOSE
//   Downstream consumer of the UART transmit FIFO on the Basys3 link.
//   Requests one character at a time from the FIFO via a one-cycle tx_ready pulse.
//   Accepts the FIFO's registered tx_valid/tx_data reply.
//   Serializes each character onto the UART TX pin as start, data LSB-first, optional parity and stop bit(s).
// PARAMETERS
//   DATA_WIDTH    8    data bits per frame (5..9)
//   CLKS_PER_BIT  868  clk cycles (with ena=1) per bit; 100 MHz / 115200 baud; must be >= 2
//   PARITY_EN     0    1 = insert parity bit after data
//   PARITY_ODD    0    1 = odd parity, 0 = even; ignored when PARITY_EN=0
//   STOP_BITS     1    number of stop bits (1 or 2)
// PORTS
//   clk        in   1           system clock
//   reset      in   1           synchronous, active-high reset
//   ena        in   1           clock enable; all state, counters and outputs hold when 0
//   tx_data    in   DATA_WIDTH  character from FIFO; valid only with tx_valid
//   tx_valid   in   1           FIFO reply, one cycle after a tx_ready pulse
//   tx_ready   out  1           one-cycle request pulse to FIFO
//   uart_tx    out  1           serial line; idles high
//   busy       out  1           high from capture until end of last stop bit
//   tx_done    out  1           one-cycle pulse on the final cycle of the last stop bit
//   overrun    out  1           sticky; tx_valid seen outside WAIT; cleared only by reset
// BEHAVIOUR
//   Reset (sync, highest priority, overrides ena)
//     - state=IDLE, uart_tx=1, busy=0, tx_done=0, overrun=0, counters=0.
//     - Mid-frame reset aborts the frame; uart_tx=1 on the next cycle.
//   States: IDLE -> WAIT -> START -> DATA -> [PARITY] -> STOP -> IDLE
//   IDLE
//     - tx_ready = (state==IDLE) & ena, combinational.
//     - Lasts exactly one enabled cycle, then WAIT.
//   WAIT (tx_ready=0)
//     - tx_valid=1: latch tx_data into shift reg, set busy, -> START.
//     - tx_valid=0: FIFO empty, -> IDLE, which pulses again.
//     - Exactly one FIFO pop per request.
//   Bit timing
//     - START/DATA/PARITY/STOP each hold uart_tx for CLKS_PER_BIT enabled cycles.
//     - Baud counter counts 0..CLKS_PER_BIT-1; width $clog2(CLKS_PER_BIT).
//     - Bit index counts 0..DATA_WIDTH-1 in DATA; 0..STOP_BITS-1 in STOP.
//   Line drive: uart_tx registered. START=0; DATA=shift[0], shift right per bit; PARITY=^data ^ PARITY_ODD; STOP=1.
//   Latency
//     - Capture in WAIT at cycle T -> uart_tx falls at T+1.
//     - Frame = (2+DATA_WIDTH+PARITY_EN+STOP_BITS-1)*CLKS_PER_BIT cycles.
//   Frame end
//     - tx_done=1 and busy->0 on the last STOP cycle.
//     - Next cycle IDLE; back-to-back frames have exactly 2 extra line-high cycles (IDLE, WAIT).
//   Overrun
//     - tx_valid=1 in any state other than WAIT sets overrun.
//     - That data is dropped; the current frame is unaffected.
//   ena=0: freezes FSM, counters, shift reg; outputs hold; tx_ready forced 0; tx_valid ignored.
// TESTING (CLKS_PER_BIT=4, DATA_WIDTH=8 unless noted)
//   1. Reset, tx_valid=0 -> uart_tx=1; tx_ready pulses every 2nd cycle; busy=0.
//   2. Reply 0x55 in WAIT -> line 0 x4, then 1,0,1,0,1,0,1,0 x4 each, then 1 x4; tx_done once; frame 40 cycles.
//   3. PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1; PARITY_ODD=1 -> 0; frame 44 cycles.
//   4. Back-to-back 0xA3 then 0x3C, FIFO answers every request -> 2 frames; exactly 2 idle-high cycles between stop and next start.
//   5. ena low 10 cycles mid-DATA -> uart_tx and counters hold; frame stretched by 10 cycles; data bits intact.
//   6. tx_valid pulse during START -> overrun=1 sticky, frame bits unchanged.
//      Then reset mid-DATA -> next cycle uart_tx=1, busy=0, overrun=0.

Source files
------------

// File: rtl/uart_tx_serializer_if.sv
// Purpose: request/reply link between the UART transmit FIFO and the serializer.
// Latency: wires only; the FIFO answers a tx_ready pulse with tx_valid/tx_data one cycle later.
// Backpressure: the serializer pulls exactly one character per request and never stalls a reply.
interface uart_tx_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    // FIFO side: answers requests
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    // Serializer side: issues requests and consumes replies
    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// Purpose: pulls one character per request from the TX FIFO and shifts it out as a UART frame.
// Latency: capture in WAIT at cycle T drives the start bit at T+1; frame lasts (1+DW+PAR+STOP)*CLKS_PER_BIT.
// Backpressure: none upstream; ena=0 freezes everything, and replies outside WAIT are dropped and flagged.
module uart_tx_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0,
    parameter int STOP_BITS    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ena,
    uart_tx_serializer_if.slave fifo_if,
    output logic                uart_tx,
    output logic                busy,
    output logic                tx_done,
    output logic                overrun
);
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      baud_q, baud_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  line_q, line_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ovr_q, ovr_d;
    logic                  baud_last;

    // Next-state, counters and registered line/status outputs; nothing moves while ena is low.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        line_d    = line_q;
        busy_d    = busy_q;
        done_d    = done_q;
        ovr_d     = ovr_q;
        baud_last = (baud_q == BAUD_LAST);

        if (ena) begin
            done_d = 1'b0;
            // A reply we did not ask for is lost; remember that it happened.
            if (fifo_if.tx_valid && (state_q != S_WAIT)) begin
                ovr_d = 1'b1;
            end

            unique case (state_q)
                S_IDLE: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (fifo_if.tx_valid) begin
                        shift_d = fifo_if.tx_data;
                        par_d   = (^fifo_if.tx_data) ^ PARITY_ODD;
                        busy_d  = 1'b1;
                        line_d  = 1'b0;
                        baud_d  = '0;
                        idx_d   = '0;
                        state_d = S_START;
                    end else begin
                        // FIFO was empty: go back and ask again.
                        state_d = S_IDLE;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud_d  = '0;
                        idx_d   = '0;
                        line_d  = shift_q[0];
                        shift_d = shift_q >> 1;
                        state_d = S_DATA;
                    end else begin
                        baud_d = baud_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_d = '0;
                        if (idx_q == DATA_LAST) begin
                            idx_d = '0;
                            if (PARITY_EN) begin
                                line_d  = par_q;
                                state_d = S_PARITY;
                            end else begin
                                line_d  = 1'b1;
                                state_d = S_STOP;
                            end
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            line_d  = shift_q[0];
                            shift_d = shift_q >> 1;
                        end
                    end else begin
                        baud_d = baud_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (baud_last) begin
                        baud_d  = '0;
                        idx_d   = '0;
                        line_d  = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        baud_d = baud_q + 1'b1;
                    end
                end
                S_STOP: begin
                    // Outputs are registered, so done/busy are staged one cycle ahead
                    // to land on the final cycle of the last stop bit.
                    if ((idx_q == STOP_LAST) && (baud_q == BAUD_PRE)) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end
                    if (baud_last) begin
                        baud_d = '0;
                        if (idx_q == STOP_LAST) begin
                            idx_d   = '0;
                            state_d = S_IDLE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        baud_d = baud_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State register with synchronous reset that overrides ena.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign fifo_if.tx_ready = (state_q == S_IDLE) && ena;
    assign uart_tx          = line_q;
    assign busy             = busy_q;
    assign tx_done          = done_q;
    assign overrun          = ovr_q;
endmodule
